// File: rtl/rv_decode_stage.sv
// RISC-V decode stage: classifies a fetched instruction, forms its immediate and flags illegal encodings.
// A main/skid register pair keeps in_ready registered while preserving order under back-pressure.
module rv_decode_stage #(
    parameter int XLEN      = 32,
    parameter bit SUPPORT_M = 1'b0,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [9:0]       out_class,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] cnt_decoded,
    output logic [CNT_W-1:0] cnt_illegal
);

    localparam logic [6:0] OP_ALUREG = 7'b0110011;
    localparam logic [6:0] OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [9:0]      cls;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm;
        logic            ill;
    } entry_t;

    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
    logic [9:0]         cls;
    logic               bad;
    logic [2:0]         f3;
    logic [6:0]         f7;
    entry_t             dec_p0;

    // Stage p0: combinational decode of the incoming word
    always_comb begin
        f3      = in_instr[14:12];
        f7      = in_instr[31:25];
        imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
        imm_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        imm_b   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
        imm_u   = {in_instr[31:12], 12'b0};
        imm_j   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
        imm_sel = '0;
        cls     = '0;
        bad     = 1'b0;
        case (in_instr[6:0])
            OP_ALUREG: begin
                cls[0] = 1'b1;
                case (f7)
                    7'h00:   bad = 1'b0;
                    7'h20:   bad = !(f3 == 3'd0 || f3 == 3'd5);
                    7'h01:   bad = !SUPPORT_M;
                    default: bad = 1'b1;
                endcase
            end
            OP_ALUIMM: begin
                cls[1]  = 1'b1;
                imm_sel = imm_i;
                // RV64 uses instr[25] as shamt[5], so only the upper six bits constrain shifts
                if (f3 == 3'd1)
                    bad = (XLEN == 64) ? (in_instr[31:26] != 6'h00) : (f7 != 7'h00);
                else if (f3 == 3'd5)
                    bad = (XLEN == 64) ? !(in_instr[31:26] == 6'h00 || in_instr[31:26] == 6'h10)
                                       : !(f7 == 7'h00 || f7 == 7'h20);
            end
            OP_BRANCH: begin
                cls[2]  = 1'b1;
                imm_sel = imm_b;
                bad     = (f3 == 3'd2 || f3 == 3'd3);
            end
            OP_JALR: begin
                cls[3]  = 1'b1;
                imm_sel = imm_i;
                bad     = (f3 != 3'd0);
            end
            OP_JAL: begin
                cls[4]  = 1'b1;
                imm_sel = imm_j;
            end
            OP_AUIPC: begin
                cls[5]  = 1'b1;
                imm_sel = imm_u;
            end
            OP_LUI: begin
                cls[6]  = 1'b1;
                imm_sel = imm_u;
            end
            OP_LOAD: begin
                cls[7]  = 1'b1;
                imm_sel = imm_i;
                case (f3)
                    3'd0, 3'd1, 3'd2, 3'd4, 3'd5: bad = 1'b0;
                    3'd3, 3'd6:                   bad = (XLEN != 64);
                    default:                      bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                cls[8]  = 1'b1;
                imm_sel = imm_s;
                bad     = (f3 > 3'd2) && !(XLEN == 64 && f3 == 3'd3);
            end
            OP_SYSTEM: begin
                cls[9]  = 1'b1;
                imm_sel = imm_i;
                bad     = (f3 == 3'd4);
            end
            default: bad = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11)
            bad = 1'b1;

        dec_p0.pc  = in_pc;
        dec_p0.cls = bad ? 10'd0 : cls;
        dec_p0.rs1 = in_instr[19:15];
        dec_p0.rs2 = in_instr[24:20];
        dec_p0.rd  = in_instr[11:7];
        dec_p0.f3  = f3;
        dec_p0.f7  = f7;
        dec_p0.imm = bad ? '0 : sext32(imm_sel);
        dec_p0.ill = bad;
    end

    entry_t m_p1, s_p1, m_nxt, s_nxt;
    logic   vld_p1, s_vld_p1, rdy_p1;
    logic   vld_nxt, s_vld_nxt;
    logic   accept, drain;

    assign accept = in_valid && rdy_p1;
    assign drain  = vld_p1 && out_ready;

    always_comb begin
        m_nxt     = m_p1;
        s_nxt     = s_p1;
        vld_nxt   = vld_p1;
        s_vld_nxt = s_vld_p1;
        if (!vld_p1 || drain) begin
            if (s_vld_p1) begin
                m_nxt     = s_p1;
                vld_nxt   = 1'b1;
                s_vld_nxt = accept;
                if (accept)
                    s_nxt = dec_p0;
            end else begin
                vld_nxt = accept;
                if (accept)
                    m_nxt = dec_p0;
            end
        end else if (accept) begin
            s_nxt     = dec_p0;
            s_vld_nxt = 1'b1;
        end
        if (flush) begin
            vld_nxt   = 1'b0;
            s_vld_nxt = 1'b0;
        end
    end

    // Stage p1: main output register, handshake state and event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            s_vld_p1    <= 1'b0;
            rdy_p1      <= 1'b0;
            m_p1        <= '0;
            cnt_decoded <= '0;
            cnt_illegal <= '0;
        end else begin
            vld_p1   <= vld_nxt;
            s_vld_p1 <= s_vld_nxt;
            rdy_p1   <= !s_vld_nxt;
            m_p1     <= m_nxt;
            if (drain) begin
                if (m_p1.ill)
                    cnt_illegal <= cnt_illegal + CNT_W'(1);
                else
                    cnt_decoded <= cnt_decoded + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        s_p1 <= s_nxt;
    end

    assign in_ready    = rdy_p1;
    assign out_valid   = vld_p1;
    assign out_pc      = m_p1.pc;
    assign out_class   = m_p1.cls;
    assign out_rs1     = m_p1.rs1;
    assign out_rs2     = m_p1.rs2;
    assign out_rd      = m_p1.rd;
    assign out_funct3  = m_p1.f3;
    assign out_funct7  = m_p1.f7;
    assign out_imm     = m_p1.imm;
    assign out_illegal = m_p1.ill;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: three configurations (RV32, RV32+M, RV64) share one stimulus stream.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [63:0] in_pc64;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm, cnt_decoded, cnt_illegal;
    logic [9:0]  out_class;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;

    logic        m_in_ready, m_out_valid, m_out_illegal;
    logic [31:0] m_out_pc, m_out_imm, m_cnt_decoded, m_cnt_illegal;
    logic [9:0]  m_out_class;
    logic [4:0]  m_out_rs1, m_out_rs2, m_out_rd;
    logic [2:0]  m_out_funct3;
    logic [6:0]  m_out_funct7;

    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [63:0] w_out_pc, w_out_imm;
    logic [31:0] w_cnt_decoded, w_cnt_illegal;
    logic [9:0]  w_out_class;
    logic [4:0]  w_out_rs1, w_out_rs2, w_out_rd;
    logic [2:0]  w_out_funct3;
    logic [6:0]  w_out_funct7;

    rv_decode_stage #(.XLEN(32), .SUPPORT_M(1'b0), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_class(out_class), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_illegal(out_illegal), .cnt_decoded(cnt_decoded), .cnt_illegal(cnt_illegal));

    rv_decode_stage #(.XLEN(32), .SUPPORT_M(1'b1), .CNT_W(32)) dut_m (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_pc(m_out_pc),
        .out_class(m_out_class), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_rd(m_out_rd),
        .out_funct3(m_out_funct3), .out_funct7(m_out_funct7), .out_imm(m_out_imm),
        .out_illegal(m_out_illegal), .cnt_decoded(m_cnt_decoded), .cnt_illegal(m_cnt_illegal));

    rv_decode_stage #(.XLEN(64), .SUPPORT_M(1'b0), .CNT_W(32)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_instr(in_instr), .in_pc(in_pc64), .flush(flush),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc),
        .out_class(w_out_class), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_rd(w_out_rd),
        .out_funct3(w_out_funct3), .out_funct7(w_out_funct7), .out_imm(w_out_imm),
        .out_illegal(w_out_illegal), .cnt_decoded(w_cnt_decoded), .cnt_illegal(w_cnt_illegal));

    always #5 clk = ~clk;

    // cls: class when legal; imm: 64-bit sign-extended immediate when legal; i32/im/i64: illegal per config
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [9:0]  cls;
        logic [63:0] imm;
        logic        i32, im, i64;
    } exp_t;

    exp_t cur;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_dec[3];
    int   exp_ill[3];
    logic acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
        end
    endtask

    task automatic count(input int k, input logic ill);
        if (ill) exp_ill[k]++;
        else     exp_dec[k]++;
    endtask

    // One clock: scoreboard work at the falling edge, return 1 time unit after the rising edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        acc = 1'b0;
        if (reset) begin
            sb.delete();
            for (int k = 0; k < 3; k++) begin
                exp_dec[k] = 0;
                exp_ill[k] = 0;
            end
        end else begin
            if (out_valid && out_ready) begin
                chk("out_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pc", 64'(out_pc), 64'(e.pc));
                    chk("class", 64'(out_class), 64'(e.i32 ? 10'd0 : e.cls));
                    chk("fields", 64'({out_rd, out_rs1, out_rs2, out_funct3, out_funct7}),
                        64'({e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12], e.instr[31:25]}));
                    chk("imm", 64'(out_imm), e.i32 ? 64'd0 : 64'(e.imm[31:0]));
                    chk("illegal", 64'(out_illegal), 64'(e.i32));
                    chk("m_valid", 64'(m_out_valid), 64'd1);
                    chk("m_class", 64'(m_out_class), 64'(e.im ? 10'd0 : e.cls));
                    chk("m_imm", 64'(m_out_imm), e.im ? 64'd0 : 64'(e.imm[31:0]));
                    chk("m_illegal", 64'(m_out_illegal), 64'(e.im));
                    chk("w_valid", 64'(w_out_valid), 64'd1);
                    chk("w_pc", w_out_pc, {32'hA5A5_0000, e.pc});
                    chk("w_class", 64'(w_out_class), 64'(e.i64 ? 10'd0 : e.cls));
                    chk("w_fields", 64'({w_out_rd, w_out_rs1, w_out_rs2, w_out_funct3, w_out_funct7}),
                        64'({e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12], e.instr[31:25]}));
                    chk("w_imm", w_out_imm, e.i64 ? 64'd0 : e.imm);
                    chk("w_illegal", 64'(w_out_illegal), 64'(e.i64));
                    count(0, e.i32);
                    count(1, e.im);
                    count(2, e.i64);
                end
            end
            if (flush)
                sb.delete();
            else if (in_valid && in_ready) begin
                sb.push_back(cur);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc, input logic [9:0] cls,
                           input logic [63:0] imm, input logic i32, input logic im, input logic i64);
        cur.instr = instr; cur.pc = pc; cur.cls = cls; cur.imm = imm;
        cur.i32 = i32; cur.im = im; cur.i64 = i64;
        in_instr = instr;
        in_pc    = pc;
        in_pc64  = {32'hA5A5_0000, pc};
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [9:0] cls,
                        input logic [63:0] imm, input logic i32, input logic im, input logic i64);
        int n;
        present(instr, pc, cls, imm, i32, im, i64);
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 50);
        chk("accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic chk_counters();
        chk("cnt_decoded", 64'(cnt_decoded), 64'(exp_dec[0]));
        chk("cnt_illegal", 64'(cnt_illegal), 64'(exp_ill[0]));
        chk("m_cnt_decoded", 64'(m_cnt_decoded), 64'(exp_dec[1]));
        chk("m_cnt_illegal", 64'(m_cnt_illegal), 64'(exp_ill[1]));
        chk("w_cnt_decoded", 64'(w_cnt_decoded), 64'(exp_dec[2]));
        chk("w_cnt_illegal", 64'(w_cnt_illegal), 64'(exp_ill[2]));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_pc64 = '0;
        cur = '{default: '0};
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk_counters();
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // addi x1,x0,-1 with one-cycle latency
        out_ready = 1'b1;
        send(32'hFFF00093, 32'h100, 10'b0000000010, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        chk("latency_valid", 64'(out_valid), 64'd1);
        tick();
        chk_counters();

        // back-pressure: two fill M and S, third waits for the drain
        out_ready = 1'b0;
        send(32'hFE20AE23, 32'h104, 10'b0100000000, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
        send(32'h001000EF, 32'h108, 10'b0000010000, 64'h0000_0000_0000_0800, 0, 0, 0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("held_pc", 64'(out_pc), 64'h104);
        chk("held_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        send(32'hFE000FE3, 32'h10C, 10'b0000000100, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
        tick();
        tick();
        chk("drained_sb", 64'(sb.size()), 64'd0);
        chk("drained_valid", 64'(out_valid), 64'd0);
        chk_counters();

        // illegal encodings and configuration-dependent legality
        send(32'h00000000, 32'h110, 10'd0, 64'd0, 1, 1, 1);
        send(32'h022081B3, 32'h114, 10'b0000000001, 64'd0, 1, 0, 1);
        send(32'h000010E7, 32'h118, 10'b0000001000, 64'd0, 1, 1, 1);
        send(32'h02009093, 32'h11C, 10'b0000000010, 64'h20, 1, 1, 0);
        send(32'h800002B7, 32'h120, 10'b0001000000, 64'hFFFF_FFFF_8000_0000, 0, 0, 0);
        send(32'h0080B283, 32'h124, 10'b0010000000, 64'h8, 1, 1, 0);
        tick();
        tick();
        chk_counters();

        // flush with M and S full and an incoming word
        out_ready = 1'b0;
        send(32'h00500093, 32'h200, 10'b0000000010, 64'h5, 0, 0, 0);
        send(32'h00600113, 32'h204, 10'b0000000010, 64'h6, 0, 0, 0);
        present(32'h00700193, 32'h208, 10'b0000000010, 64'h7, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk_counters();
        out_ready = 1'b1;
        tick();
        tick();
        chk("flush_no_ghost", 64'(out_valid), 64'd0);
        chk_counters();

        // reset mid-stream with both entries held
        out_ready = 1'b0;
        send(32'h00800093, 32'h300, 10'b0000000010, 64'h8, 0, 0, 0);
        send(32'h00900113, 32'h304, 10'b0000000010, 64'h9, 0, 0, 0);
        chk("pre_rst_cnt_nonzero", 64'(cnt_decoded != 0), 64'd1);
        present(32'h00A00193, 32'h308, 10'b0000000010, 64'hA, 0, 0, 0);
        reset = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_out_pc", 64'(out_pc), 64'd0);
        chk("mid_rst_out_class", 64'(out_class), 64'd0);
        chk("mid_rst_out_fields", 64'({out_rd, out_rs1, out_funct7}), 64'd0);
        chk_counters();
        reset = 1'b0;
        tick();
        chk("after_rst_in_ready", 64'(in_ready), 64'd1);
        chk("after_rst_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(32'hFFF00093, 32'h400, 10'b0000000010, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        chk("after_rst_latency", 64'(out_valid), 64'd1);
        tick();
        tick();
        chk_counters();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Registered, parametrised RISC-V decode stage sitting between instruction fetch and register-read/execute. Accepts fetched instruction+PC over a valid/ready handshake and classifies the opcode. Produces a single format-selected, XLEN-sign-extended immediate, flags illegal encodings (optional M extension, RV64 widths), and delivers the result one cycle later. Includes a 2-entry skid buffer so in_ready never depends combinationally on out_ready. Also provides a pipeline flush and decode/illegal event counters.

Parameters:
XLEN, 32, datapath width (32 or 64); sets immediate/PC width and legal load/store/shift encodings
SUPPORT_M, 0, 1 = funct7 7'b0000001 on ALUReg opcode is legal (MUL/DIV family)
CNT_W, 32, width of event counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of instruction
flush  in  1  discard all held/incoming entries
out_valid  out  1  decoded entry available
out_ready  in  1  consumer accepts
out_pc  out  XLEN  PC of entry
out_class  out  10  one-hot {System,Store,Load,LUI,AUIPC,JAL,JALR,Branch,ALUImm,ALUReg} (bit0=ALUReg)
out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_imm  out  XLEN  selected immediate
out_illegal  out  1  illegal encoding
cnt_decoded  out  CNT_W  count of output handshakes with out_illegal=0
cnt_illegal  out  CNT_W  count of output handshakes with out_illegal=1

Behaviour:
- Storage: main output register (M) + skid register (S), each with a valid bit. Decode logic is combinational on in_instr and is captured into M or S on acceptance.
- in_ready = !S.valid (registered).
- Accept when in_valid&&in_ready; drain when out_valid&&out_ready.
- M empty, or M draining this cycle: the accepted entry goes to M; if S holds an entry, S moves to M and the new entry goes to S.
- M full and not draining: the accepted entry goes to S.
- Latency 1 cycle in→out. Order strictly preserved. No loss or duplication.
- Output fields are held stable while out_valid && !out_ready.
- Immediate selection, sign-extended from instr[31] to XLEN:
  - I-form: ALUImm, JALR, Load, System.
  - S-form: Store.
  - B-form: Branch, {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U-form: LUI, AUIPC, {instr[31:12],12'b0}.
  - J-form: JAL, {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - ALUReg or illegal: imm=0.
- Illegal if any of:
  - instr[1:0]!=2'b11, or opcode not among the 10 classes.
  - ALUReg: funct7 ∉ {0x00, 0x20 (only funct3 000/101)}, plus 0x01 when SUPPORT_M=1.
  - ALUImm shifts:
    - funct3=001: XLEN=32 requires funct7=0; XLEN=64 requires instr[31:26]=0.
    - funct3=101: XLEN=32 requires funct7 ∈ {0x00,0x20}; XLEN=64 requires instr[31:26] ∈ {0x00,0x10}.
  - Load funct3 ∉ {0,1,2,4,5} (XLEN=64 adds 3,6).
  - Store funct3 > 2 (XLEN=64 allows 3).
  - Branch funct3 ∈ {2,3}.
  - JALR funct3≠0.
  - System funct3=4.
- When illegal: out_class=0 and imm=0; rs/rd/funct fields still passed raw.
- Counters increment on output handshake only and wrap at 2^CNT_W.
- flush: M.valid and S.valid cleared at the clock edge. A same-cycle input handshake is discarded. A same-cycle output handshake still counts. out_valid=0 and in_ready=1 the cycle after.
- reset (any time, including mid-stream): M/S valid=0, all output data registers=0, counters=0.
  - in_ready=0 during the reset cycle, 1 the cycle after.
  - Reset has priority over flush.

Test Plan:
1. in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, out_class=10'b0000000010, rd=1, rs1=0, imm=0xFFFFFFFF, illegal=0; cnt_decoded=1 after handshake.
2. out_ready=0, stream 3 instrs with in_valid=1 → in_ready falls after 2 accepted; raise out_ready → all 3 emerge in order, one per cycle, fields intact.
3. 0x00000000 → illegal=1, class=0, imm=0, cnt_illegal=1. 0x022081B3 (mul x3,x1,x2): SUPPORT_M=0 → illegal=1; SUPPORT_M=1 → class bit0, illegal=0.
4. M and S full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, counters unchanged, flushed instrs never appear.
5. XLEN=64: 0x800002B7 (lui x5,0x80000) → imm=0xFFFFFFFF80000000, rd=5. Load funct3=3 legal on XLEN=64, illegal on XLEN=32.
6. Assert reset with both entries held and counters nonzero → next cycle out_valid=0, counters=0, outputs=0; next post-reset instr decodes with 1-cycle latency.
